// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop input synchronizer, optional parity and
// a valid/ready output handshake that holds one completed frame.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   uart_in     asynchronous serial line, idles high
//   data_rx     received data word (LSB first on the line), valid while valid=1
//   valid       data_rx/parity_err/frame_err hold a completed frame
//   ready       consumer accepts the held frame when valid && ready
//   parity_err  parity mismatch on the held frame (always 0 when PARITY_TYPE=0)
//   frame_err   stop bit sampled low on the held frame
//   overrun     one-cycle pulse: a frame completed while valid=1 and ready=0
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(BITS_N) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY,
        STOP_BIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  bit_idx;
    logic [BITS_N-1:0] shift;
    logic              par_bad;
    logic              sync1;
    logic              sync2;
    logic              line;
    logic              par_exp_c;

    // Two-flop synchronizer; flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_in;
            sync2 <= sync1;
        end
    end

    assign line = sync2;

    // Expected parity bit for the assembled word: odd -> ~^data, even -> ^data.
    always_comb begin
        par_exp_c = ^shift;
        if (PARITY_TYPE == 1) begin
            par_exp_c = ~(^shift);
        end
    end

    // Receive FSM plus output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            data_rx    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // Consumer acceptance; a completing frame below may reload valid.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count   <= '0;
                    bit_idx <= '0;
                    par_bad <= 1'b0;
                    if (!line) begin
                        state <= START_BIT;
                    end
                end

                START_BIT: begin
                    // Re-check the line mid start bit to reject short glitches.
                    if (count == CNT_HALF) begin
                        count <= '0;
                        state <= line ? IDLE : DATA_BITS;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                DATA_BITS: begin
                    if (count == CNT_LAST) begin
                        count <= '0;
                        for (int unsigned i = 0; i < BITS_N; i++) begin
                            if (bit_idx == IDX_W'(i)) begin
                                shift[i] <= line;
                            end
                        end
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY_TYPE != 0) ? PARITY : STOP_BIT;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (count == CNT_LAST) begin
                        count   <= '0;
                        par_bad <= (line != par_exp_c);
                        state   <= STOP_BIT;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                STOP_BIT: begin
                    // Return to IDLE right at the stop sample so a following
                    // start bit is caught without waiting out the stop bit.
                    if (count == CNT_LAST) begin
                        count <= '0;
                        state <= IDLE;
                        if (!valid || ready) begin
                            data_rx    <= shift;
                            parity_err <= par_bad;
                            frame_err  <= !line;
                            valid      <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Two instances share clk/rst:
// u_rx0 without parity and u_rx2 with even parity, each on its own line.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       line0;
    logic       line2;
    logic       ready0;
    logic       ready2;
    logic [7:0] data0;
    logic [7:0] data2;
    logic       valid0;
    logic       valid2;
    logic       perr0;
    logic       perr2;
    logic       ferr0;
    logic       ferr2;
    logic       ovr0;
    logic       ovr2;

    int passed;
    int total;

    // Observation of the valid/overrun activity on each instance.
    int         vcnt0;
    int         vcnt2;
    int         ovr_cnt0;
    logic [7:0] cap_data0;
    logic       cap_perr0;
    logic       cap_ferr0;
    logic [7:0] cap_data2;
    logic       cap_perr2;

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0)) u_rx0 (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (line0),
        .data_rx    (data0),
        .valid      (valid0),
        .ready      (ready0),
        .parity_err (perr0),
        .frame_err  (ferr0),
        .overrun    (ovr0)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2)) u_rx2 (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (line2),
        .data_rx    (data2),
        .valid      (valid2),
        .ready      (ready2),
        .parity_err (perr2),
        .frame_err  (ferr2),
        .overrun    (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid0) begin
            vcnt0     = vcnt0 + 1;
            cap_data0 = data0;
            cap_perr0 = perr0;
            cap_ferr0 = ferr0;
        end
        if (valid2) begin
            vcnt2     = vcnt2 + 1;
            cap_data2 = data2;
            cap_perr2 = perr2;
        end
        if (ovr0) begin
            ovr_cnt0 = ovr_cnt0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 2) line2 = b;
        else          line0 = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, parity bit for the parity instance, stop bit.
    task automatic send(input int sel, input logic [7:0] d, input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (sel == 2) drive_bit(sel, par);
        drive_bit(sel, stop);
    endtask

    task automatic idle(input int n);
        line0 = 1'b1;
        line2 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fr;
        passed   = 0;
        total    = 0;
        vcnt0    = 0;
        vcnt2    = 0;
        ovr_cnt0 = 0;
        rst      = 1'b1;
        line0    = 1'b1;
        line2    = 1'b1;
        ready0   = 1'b1;
        ready2   = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_data",  data0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_perr",  perr0, 0);
        chk("rst_ferr",  ferr0, 0);
        chk("rst_ovr",   ovr0, 0);
        chk("rst_valid2", valid2, 0);
        rst = 1'b0;
        idle(10);

        // Plain frame, ready high: one-cycle valid
        vcnt0 = 0;
        send(0, 8'hA5, 1'b0, 1'b1);
        idle(20);
        chk("a5_vcnt", vcnt0, 1);
        chk("a5_data", cap_data0, 8'hA5);
        chk("a5_perr", cap_perr0, 0);
        chk("a5_ferr", cap_ferr0, 0);
        chk("a5_valid_low", valid0, 0);

        // Even parity: 0x37 has five ones, so the correct parity bit is 1
        vcnt2 = 0;
        send(2, 8'h37, 1'b0, 1'b1);
        idle(20);
        chk("par_bad_vcnt", vcnt2, 1);
        chk("par_bad_data", cap_data2, 8'h37);
        chk("par_bad_perr", cap_perr2, 1);
        send(2, 8'h37, 1'b1, 1'b1);
        idle(20);
        chk("par_ok_vcnt", vcnt2, 2);
        chk("par_ok_data", cap_data2, 8'h37);
        chk("par_ok_perr", cap_perr2, 0);

        // Low stop bit: frame delivered with frame_err, then recovery
        vcnt0 = 0;
        send(0, 8'hFF, 1'b0, 1'b0);
        line0 = 1'b1;
        @(negedge clk);
        chk("brk_vcnt", vcnt0, 1);
        chk("brk_data", cap_data0, 8'hFF);
        chk("brk_ferr", cap_ferr0, 1);
        idle(250);
        vcnt0 = 0;
        send(0, 8'h00, 1'b0, 1'b1);
        idle(20);
        chk("z_vcnt", vcnt0, 1);
        chk("z_data", cap_data0, 8'h00);
        chk("z_ferr", cap_ferr0, 0);

        // Short low glitch on the idle line is rejected
        vcnt0 = 0;
        line0 = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("glitch_vcnt", vcnt0, 0);
        send(0, 8'h5A, 1'b0, 1'b1);
        idle(20);
        chk("g5a_vcnt", vcnt0, 1);
        chk("g5a_data", cap_data0, 8'h5A);

        // Consumer stalled: second frame overruns and is dropped
        ready0   = 1'b0;
        ovr_cnt0 = 0;
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        idle(20);
        chk("ovr_valid", valid0, 1);
        chk("ovr_data", data0, 8'h11);
        chk("ovr_cnt", ovr_cnt0, 1);
        chk("ovr_pulse_low", ovr0, 0);
        ready0 = 1'b1;
        @(negedge clk);
        chk("ovr_valid_clr", valid0, 0);
        idle(10);

        // Reset in the middle of data bit 3 of 0xC3 abandons the frame
        vcnt0 = 0;
        fr    = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, fr[i]);
        line0 = fr[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 4; i < 8; i++) drive_bit(0, fr[i]);
        drive_bit(0, 1'b1);
        idle(4);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_vcnt", vcnt0, 0);
        chk("mrst_data", data0, 0);
        chk("mrst_valid", valid0, 0);
        chk("mrst_perr", perr0, 0);
        chk("mrst_ferr", ferr0, 0);
        chk("mrst_ovr", ovr0, 0);
        idle(10);
        send(0, 8'h3C, 1'b0, 1'b1);
        idle(20);
        chk("r3c_vcnt", vcnt0, 1);
        chk("r3c_data", cap_data0, 8'h3C);
        chk("r3c_ferr", cap_ferr0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 50_000_000/115_200, clk cycles per UART bit; SHALL be >= 4.
REQ-002 Parameter BITS_N, default 8, data bits per frame, LSB first.
REQ-003 Parameter PARITY_TYPE, default 0, 0 none / 1 odd / 2 even.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 uart_in  input  1  asynchronous serial line, idles high.
REQ-007 data_rx  output  BITS_N  received data word, valid while valid=1.
REQ-008 valid  output  1  handshake: data_rx/parity_err/frame_err hold a completed frame.
REQ-009 ready  input  1  handshake: consumer accepts the frame when valid&&ready.
REQ-010 parity_err  output  1  parity mismatch on the held frame; 0 when PARITY_TYPE=0.
REQ-011 frame_err  output  1  stop bit sampled low on the held frame.
REQ-012 overrun  output  1  one-cycle pulse: a frame completed while valid=1 and ready=0.

Function
REQ-013 uart_in SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized line (sync latency 2 cycles).
REQ-014 FSM states SHALL be IDLE, START_BIT, DATA_BITS, PARITY, STOP_BIT; a single bit counter count runs 0..CLKS_PER_BIT-1.
REQ-015 IDLE: count=0, bit index=0; synchronized line low -> START_BIT.
REQ-016 START_BIT: at count==(CLKS_PER_BIT-1)/2, if line low -> DATA_BITS with count=0; if high -> IDLE (glitch rejected, no flags, no valid).
REQ-017 DATA_BITS: at count==CLKS_PER_BIT-1, sample line into shift register bit [bit index], count=0, bit index+1; after sample BITS_N-1 -> PARITY if PARITY_TYPE!=0 else STOP_BIT.
REQ-018 PARITY: at count==CLKS_PER_BIT-1 sample parity bit -> STOP_BIT; error if sampled bit != ~^data (odd) or ^data (even).
REQ-019 STOP_BIT: at count==CLKS_PER_BIT-1 sample stop bit, frame_err source = (sample==0), -> IDLE the same cycle (next start detectable without waiting a full stop bit).
REQ-020 Frame completion (STOP_BIT sample cycle) with valid=0 or valid&&ready: next cycle data_rx, parity_err, frame_err load, valid=1.
REQ-021 Frame completion with valid=1 and ready=0: new frame discarded, held frame unchanged, overrun=1 for exactly one cycle.
REQ-022 valid SHALL remain 1 with data_rx and flags stable until a cycle with ready=1; valid clears the following cycle unless REQ-020 reloads it that cycle.
REQ-023 Frames with frame_err=1 SHALL still be delivered via valid.
REQ-024 Line low during IDLE after frame_err (break) SHALL start a new START_BIT check; no lockup.
REQ-025 bit index width SHALL be $clog2(BITS_N)+1 or wider; no wrap-around before BITS_N samples.

Reset
REQ-026 On rst: state IDLE, count 0, bit index 0, synchronizer flops 1, shift register 0.
REQ-027 On rst: data_rx 0, valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-028 rst mid-frame SHALL abandon the frame with no valid; reception resumes with the next falling edge after rst deasserts.

Verification (CLKS_PER_BIT=16, BITS_N=8 unless stated)
REQ-029 PARITY_TYPE=0, send 0xA5 with ready=1 -> valid pulses one cycle, data_rx=0xA5, parity_err=0, frame_err=0.
REQ-030 PARITY_TYPE=2, send 0x37 with parity bit 0 (wrong) -> data_rx=0x37, parity_err=1; with correct bit 1 -> parity_err=0.
REQ-031 Stop bit driven low, data 0xFF -> data_rx=0xFF, frame_err=1; next normal frame 0x00 -> frame_err=0.
REQ-032 Low glitch of 4 cycles on idle line -> no valid, FSM back in IDLE; following frame 0x5A received correctly.
REQ-033 ready=0, send 0x11 then 0x22 back-to-back -> data_rx stays 0x11, overrun pulses once at second frame end; ready=1 -> valid clears.
REQ-034 Assert rst at DATA_BITS bit 3 of frame 0xC3 -> no valid, all outputs 0; next frame 0x3C received correctly.
